// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the default frame shape used by the UART top.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int OVERSAMPLE = 16;  // ticks per bit period
  localparam int MID_SAMPLE = 7;   // tick index at the middle of the start bit

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = ST_IDLE,
    RX_START  = ST_START,
    RX_DATA   = ST_DATA,
    RX_PARITY = ST_PARITY,
    RX_STOP   = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value is a parameter
// so idle-high lines come out of reset inactive.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // metastability stage followed by the stable output stage
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver: start-bit validation, LSB-first data shift,
// optional parity (define UART_RX_PARITY_EN) and stop-bit check. Each byte is
// presented with a one-cycle o_rx_done pulse. A frame ending in a framing
// error disarms start detection until the line is seen idle-high again, so a
// break yields one errored byte rather than a stream.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DBIT       = DEF_DBIT,
  parameter int SB_TICK    = DEF_SB_TICK,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_s_tick,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done,
  output logic            o_frame_err,
  output logic            o_parity_err,
  output logic            o_busy
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic            armed_q, armed_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            par_expect;
  logic            par_sample;
  logic            rx_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  assign par_expect = (^shift_q) ^ PAR_ODD;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  // latched parity bit from the wire
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign par_sample = par_q;
`else
  // no parity bit is framed, so the "sample" always matches expectation
  assign par_sample = par_expect;
`endif

  // state, counters, shift register and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RX_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  // next-state and datapath updates; everything but IDLE exit waits on a tick
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    armed_d = armed_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      RX_IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = RX_START;
          s_d     = '0;
        end
      end
      RX_START: begin
        if (i_s_tick) begin
          if (s_q == SW'(MID_SAMPLE)) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = RX_IDLE;  // glitch, not a real start bit
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (i_s_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            shift_d = {rx_s, shift_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (i_s_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = RX_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
`else
        state_d = RX_IDLE;
`endif
      end
      RX_STOP: begin
        if (i_s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = RX_IDLE;
            s_d     = '0;
            done_d  = 1'b1;
            dout_d  = shift_q;
            ferr_d  = ~rx_s;
            perr_d  = par_sample ^ par_expect;
            armed_d = rx_s;  // low stop bit: wait for idle-high before rearming
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_dout       = dout_q;
  assign o_rx_done    = done_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of single frames plus hand-written
// glitch, break, back-to-back, mid-frame reset and parity sequences.
// Ticks arrive every 4 clocks, so one bit period is 64 clocks.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       done, ferr, perr, busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } rec_t;
  rec_t got_q[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       par;
    logic [7:0] exp_d;
    logic       exp_f;
    logic       exp_p;
  } vec_t;
  vec_t tbl[6];

  uart_rx_frame dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_s_tick     (tick),
    .i_rx         (rx),
    .o_dout       (dout),
    .o_rx_done    (done),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // one-cycle tick every fourth clock
  initial forever begin
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  end

  // capture every cycle that done is high; a stretched pulse shows as extra records
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      got_q.push_back({dout, ferr, perr});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par);
    send_bit(stop);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] d, input logic f, input logic p);
    rec_t r;
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no done pulse, expected dout %0h", name, d);
    end else begin
      r = got_q.pop_front();
      chk({name, " dout"}, 32'(r.d), 32'(d));
      chk({name, " frame_err"}, 32'(r.f), 32'(f));
      chk({name, " parity_err"}, 32'(r.p), 32'(p));
    end
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};

    // reset state
    repeat (5) @(negedge clk);
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset frame_err", 32'(ferr), 32'h0);
    chk("reset parity_err", 32'(perr), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    rst = 1'b0;
    send_bit(1'b1);

    // table of single frames separated by idle time
    for (int i = 0; i < 6; i++) begin
      got_q.delete();
      send_frame(tbl[i].d, tbl[i].stop, tbl[i].par);
      send_bit(1'b1);
      send_bit(1'b1);
      chk($sformatf("vec%0d count", i), 32'(got_q.size()), 32'd1);
      pop_chk($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_f, tbl[i].exp_p);
      chk($sformatf("vec%0d busy after", i), 32'(busy), 32'h0);
    end

    // start glitch: low for 3 ticks only
    got_q.delete();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch busy in start", 32'(busy), 32'h1);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("glitch back to idle", 32'(busy), 32'h0);
    chk("glitch no done", 32'(got_q.size()), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_bit(1'b1);
    pop_chk("after glitch", 8'h3C, 1'b0, 1'b0);

    // break: stop bit low, line held low for 3 frame times
    got_q.delete();
    send_frame(8'h5A, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * 10 * BIT_CLKS) @(negedge clk);
    chk("break single done", 32'(got_q.size()), 32'd1);
    chk("break idle while low", 32'(busy), 32'h0);
    pop_chk("break", 8'h5A, 1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("post-break count", 32'(got_q.size()), 32'd1);
    pop_chk("post-break", 8'h81, 1'b0, 1'b0);

    // back-to-back frames, no idle gap
    got_q.delete();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("b2b count", 32'(got_q.size()), 32'd2);
    pop_chk("b2b first", 8'h00, 1'b0, 1'b0);
    pop_chk("b2b second", 8'hFF, 1'b0, 1'b0);

    // reset after four data bits of 0x77
    got_q.delete();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset dout", 32'(dout), 32'h0);
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    chk("midreset no done", 32'(got_q.size()), 32'd0);
    send_frame(8'hC3, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("after reset count", 32'(got_q.size()), 32'd1);
    pop_chk("after reset", 8'hC3, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 has three ones, so the parity bit should be 1
    got_q.delete();
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    pop_chk("parity good", 8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    pop_chk("parity bad", 8'h07, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
